// File: rtl/mine_placer_if.sv
// Request/response bundle between the game controller and mine_placer.
// master drives the start request, slave returns status and the mine map.
interface mine_placer_if #(
    parameter int ROWS  = 5,
    parameter int COLS  = 5,
    parameter int CNT_W = 5
);
    localparam int CELLS = ROWS * COLS;
    localparam int IDX_W = $clog2(CELLS);

    logic              in_start;
    logic [15:0]       in_seed;
    logic [CNT_W-1:0]  in_mines_num;
    logic [IDX_W-1:0]  in_safe_idx;
    logic              out_busy;
    logic              out_done;
    logic              out_err;
    logic [CELLS-1:0]  out_mines;
    logic [CNT_W-1:0]  out_mine_count;

    modport master (
        output in_start, in_seed, in_mines_num, in_safe_idx,
        input  out_busy, out_done, out_err, out_mines, out_mine_count
    );

    modport slave (
        input  in_start, in_seed, in_mines_num, in_safe_idx,
        output out_busy, out_done, out_err, out_mines, out_mine_count
    );
endinterface

// File: rtl/mine_placer.sv
// LFSR-driven mine placer, one draw per cycle; MINE_SAFE_ZONE_EN also excludes the safe cell's neighbours.
// Latency accept->done = draws+1 cycles; in_start is ignored while busy (no queueing).
module mine_placer #(
    parameter int ROWS      = 5,
    parameter int COLS      = 5,
    parameter int CNT_W     = 5,
    parameter int MAX_DRAWS = 1024
) (
    input  logic          in_clka,
    input  logic          in_rst_n,
    mine_placer_if.slave  bus
);
    localparam int CELLS  = ROWS * COLS;
    localparam int IDX_W  = $clog2(CELLS);
    localparam int DRAW_W = $clog2(MAX_DRAWS + 1);
`ifdef MINE_SAFE_ZONE_EN
    localparam int LIMIT  = CELLS - 9;
`else
    localparam int LIMIT  = CELLS - 1;
`endif
    localparam logic [15:0]       SEED_DFLT = 16'hACE1;
    localparam logic [DRAW_W-1:0] LAST_DRAW = DRAW_W'(MAX_DRAWS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ERR} state_t;

    state_t             state_q, state_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [CNT_W-1:0]   target_q, target_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [IDX_W-1:0]   safe_q, safe_d;
    logic [CELLS-1:0]   mines_q, mines_d;
    logic [DRAW_W-1:0]  draws_q, draws_d;
    logic               err_run_q, err_run_d;

    logic [IDX_W-1:0]   cand;
    logic [CNT_W-1:0]   count_inc;
    logic               excluded;
    logic               cand_ok;
    logic               illegal;

    assign cand      = lfsr_q[IDX_W-1:0];
    assign count_inc = count_q + 1'b1;
    assign illegal   = (int'(bus.in_mines_num) > LIMIT) || (int'(bus.in_safe_idx) >= CELLS);

`ifdef MINE_SAFE_ZONE_EN
    // Row/column distance test keeps column-edge neighbours from wrapping rows.
    always_comb begin
        int dr;
        int dc;
        dr = int'(cand) / COLS - int'(safe_q) / COLS;
        dc = int'(cand) % COLS - int'(safe_q) % COLS;
        excluded = (dr >= -1) && (dr <= 1) && (dc >= -1) && (dc <= 1);
    end
`else
    assign excluded = (cand == safe_q);
`endif

    assign cand_ok = (int'(cand) < CELLS) && !mines_q[cand] && !excluded;

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        target_d  = target_q;
        count_d   = count_q;
        safe_d    = safe_q;
        mines_d   = mines_q;
        draws_d   = draws_q;
        err_run_d = err_run_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_start) begin
                    lfsr_d    = (bus.in_seed == 16'h0000) ? SEED_DFLT : bus.in_seed;
                    target_d  = bus.in_mines_num;
                    safe_d    = bus.in_safe_idx;
                    mines_d   = '0;
                    count_d   = '0;
                    draws_d   = '0;
                    err_run_d = 1'b0;
                    if (illegal)
                        state_d = S_ERR;
                    else if (bus.in_mines_num == '0)
                        state_d = S_DONE;
                    else
                        state_d = S_RUN;
                end
            end
            S_RUN: begin
                lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
                draws_d = draws_q + 1'b1;
                if (cand_ok) begin
                    mines_d[cand] = 1'b1;
                    count_d       = count_inc;
                end
                // A completing draw wins over the watchdog on the same cycle.
                if (cand_ok && (count_inc == target_q)) begin
                    state_d = S_DONE;
                end else if (draws_q == LAST_DRAW) begin
                    state_d   = S_ERR;
                    err_run_d = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge in_clka or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q   <= S_IDLE;
            lfsr_q    <= SEED_DFLT;
            target_q  <= '0;
            count_q   <= '0;
            safe_q    <= '0;
            mines_q   <= '0;
            draws_q   <= '0;
            err_run_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            target_q  <= target_d;
            count_q   <= count_d;
            safe_q    <= safe_d;
            mines_q   <= mines_d;
            draws_q   <= draws_d;
            err_run_q <= err_run_d;
        end
    end

    assign bus.out_busy       = (state_q == S_RUN) || (state_q == S_DONE) ||
                                ((state_q == S_ERR) && err_run_q);
    assign bus.out_done       = (state_q == S_DONE);
    assign bus.out_err        = (state_q == S_ERR);
    assign bus.out_mines      = mines_q;
    assign bus.out_mine_count = count_q;
endmodule

// File: tb/tb_mine_placer.sv
// Scoreboarded bench for mine_placer on the default 5x5 board: the driver queues expected
// results per accepted start, the monitor checks each done/err pulse against the queue head.
module tb_mine_placer;
    localparam int ROWS = 5, COLS = 5, CNT_W = 5, MAX_DRAWS = 1024;
    localparam int CELLS = ROWS * COLS;
    localparam int IDX_W = $clog2(CELLS);
`ifdef MINE_SAFE_ZONE_EN
    localparam int LIMIT = CELLS - 9;
`else
    localparam int LIMIT = CELLS - 1;
`endif

    typedef struct {
        int               id;
        bit               is_err;
        logic [CELLS-1:0] mines;
        int               count;
        int               lat;
        bit               busy;
        int               acc;
    } item_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    item_t sb[$];

    mine_placer_if #(.ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W)) bus ();

    mine_placer #(.ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W), .MAX_DRAWS(MAX_DRAWS)) dut (
        .in_clka  (clk),
        .in_rst_n (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit excl(input int cand, input int safe);
`ifdef MINE_SAFE_ZONE_EN
        int dr = cand / COLS - safe / COLS;
        int dc = cand % COLS - safe % COLS;
        return (dr >= -1) && (dr <= 1) && (dc >= -1) && (dc <= 1);
`else
        return cand == safe;
`endif
    endfunction

    // Reference placement straight from the behavioural description.
    function automatic item_t model(input int id, input logic [15:0] seed, input int cnt, input int safe);
        item_t it;
        logic [15:0] l;
        int c, d, cand;
        it.id = id; it.acc = 0; it.mines = '0;
        if (cnt > LIMIT || safe >= CELLS) begin
            it.is_err = 1'b1; it.count = 0; it.lat = 1; it.busy = 1'b0;
            return it;
        end
        l = (seed == 16'h0000) ? 16'hACE1 : seed;
        c = 0; d = 0;
        while (c < cnt && d < MAX_DRAWS) begin
            cand = int'(l) % (1 << IDX_W);
            if (cand < CELLS && !it.mines[cand] && !excl(cand, safe)) begin
                it.mines[cand] = 1'b1;
                c++;
            end
            l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
            d++;
        end
        it.is_err = (c != cnt);
        it.count  = c;
        it.lat    = d + 1;
        it.busy   = 1'b1;
        return it;
    endfunction

    always @(negedge clk) begin
        if (rst_n && (bus.out_done || bus.out_err)) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {62'd0, bus.out_done, bus.out_err}, 64'd0);
            end else begin
                item_t it;
                it = sb.pop_front();
                chk($sformatf("run%0d_done", it.id), bus.out_done, !it.is_err);
                chk($sformatf("run%0d_err", it.id), bus.out_err, it.is_err);
                chk($sformatf("run%0d_mines", it.id), bus.out_mines, it.mines);
                chk($sformatf("run%0d_count", it.id), bus.out_mine_count, it.count);
                chk($sformatf("run%0d_latency", it.id), cyc - it.acc + 1, it.lat);
                chk($sformatf("run%0d_busy", it.id), bus.out_busy, it.busy);
                chk($sformatf("run%0d_popcount", it.id), $countones(bus.out_mines), bus.out_mine_count);
            end
        end
    end

    task automatic issue(input logic [15:0] seed, input int cnt, input int safe,
                         input bit push, input item_t exp);
        @(negedge clk);
        bus.in_start     = 1'b1;
        bus.in_seed      = seed;
        bus.in_mines_num = CNT_W'(cnt);
        bus.in_safe_idx  = IDX_W'(safe);
        @(posedge clk);
        #1;
        bus.in_start = 1'b0;
        if (push) begin
            item_t it;
            it = exp;
            it.acc = cyc;
            sb.push_back(it);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((sb.size() != 0 || bus.out_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", n < budget, 1'b1);
        if (n >= budget) sb.delete();
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int id, input logic [15:0] seed, input int cnt, input int safe);
        issue(seed, cnt, safe, 1'b1, model(id, seed, cnt, safe));
        wait_idle(3000);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        item_t hand, dummy;
        logic [CELLS-1:0] board_a, board_b, board_c;

        bus.in_start = 1'b0; bus.in_seed = '0; bus.in_mines_num = '0; bus.in_safe_idx = '0;
        dummy = model(0, 16'h0001, 0, 0);
        repeat (3) @(negedge clk);
        chk("reset_mines", bus.out_mines, '0);
        chk("reset_count", bus.out_mine_count, '0);
        chk("reset_flags", {bus.out_busy, bus.out_done, bus.out_err}, 3'b000);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero seed must behave as the default seed.
        run(1, 16'h0000, 5, 12);
        board_a = bus.out_mines;
        run(2, 16'hACE1, 5, 12);
        board_b = bus.out_mines;
        chk("seed0_equals_ace1", board_a, board_b);

        hand = '{id: 3, is_err: 1'b0, mines: '0, count: 0, lat: 1, busy: 1'b1, acc: 0};
        issue(16'h1234, 0, 3, 1'b1, hand);
        wait_idle(100);

        // Densest legal board: every cell except the safe one.
        hand = model(4, 16'h3C5A, 24, 0);
`ifdef MINE_SAFE_ZONE_EN
        hand.is_err = 1'b1; hand.mines = '0; hand.count = 0; hand.lat = 1; hand.busy = 1'b0;
`else
        hand.is_err = 1'b0; hand.mines = 25'h1FFFFFE; hand.count = 24; hand.busy = 1'b1;
`endif
        issue(16'h3C5A, 24, 0, 1'b1, hand);
        wait_idle(3000);
        repeat (3) @(negedge clk);
        chk("hold_after_end", bus.out_mines, hand.mines);

        run(5, 16'h0001, 1, 0);
        hand = '{id: 6, is_err: 1'b1, mines: '0, count: 0, lat: 1, busy: 1'b0, acc: 0};
        issue(16'h4321, 25, 0, 1'b1, hand);
        wait_idle(100);
        hand.id = 7;
        issue(16'h4321, 3, 25, 1'b1, hand);
        wait_idle(100);
        run(8, 16'h1234, 10, 24);
        run(9, 16'hFFFF, LIMIT, 6);

        // A start arriving mid-run must not disturb the board.
        issue(16'h1234, 15, 7, 1'b1, model(10, 16'h1234, 15, 7));
        repeat (3) @(negedge clk);
        chk("busy_mid_run", bus.out_busy, 1'b1);
        issue(16'hBEEF, 3, 1, 1'b0, dummy);
        wait_idle(3000);
        board_c = bus.out_mines;
        run(11, 16'h1234, 15, 7);
        chk("ignored_start_board", bus.out_mines, board_c);

        // Reset in the middle of a run clears everything at once.
        issue(16'h5555, 15, 12, 1'b0, dummy);
        repeat (4) @(negedge clk);
        chk("pre_reset_busy", bus.out_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_mines", bus.out_mines, '0);
        chk("midrst_count", bus.out_mine_count, '0);
        chk("midrst_flags", {bus.out_busy, bus.out_done, bus.out_err}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(12, 16'h5555, 15, 12);

        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
